// File: rtl/read_empty.sv
// Read-domain half of an asynchronous FIFO: binary/Gray read pointer, registered
// empty flag, occupancy count, sticky underflow flag and optional almost-empty flag.
// Optional feature: define READ_EMPTY_ALMOST_EN to build the almost-empty flag;
// otherwise ralmost_empty is tied low.
module read_empty #(
   parameter int unsigned ADDRESS_BITS       = 4,
   parameter int unsigned ALMOST_EMPTY_LEVEL = 2
) (
   input  logic                    rclk,
   input  logic                    rrst,
   input  logic                    rinc,
   input  logic [ADDRESS_BITS:0]   rq2_write_ptr,
   output logic [ADDRESS_BITS-1:0] raddr,
   output logic [ADDRESS_BITS:0]   rptr,
   output logic                    rempty,
   output logic [ADDRESS_BITS:0]   rcount,
   output logic                    runderflow,
   output logic                    ralmost_empty
);

   localparam int unsigned PtrW = ADDRESS_BITS + 1;

   // A level above the depth would make the flag permanently set.
   if (ALMOST_EMPTY_LEVEL > (1 << ADDRESS_BITS)) begin : g_bad_level
      $error("read_empty: ALMOST_EMPTY_LEVEL exceeds FIFO depth");
   end

   logic [PtrW-1:0] rbin;
   logic [PtrW-1:0] rbinnext;
   logic [PtrW-1:0] rgraynext;
   logic [PtrW-1:0] wbin_s;
   logic [PtrW-1:0] occ_next;
   logic            pop;

   assign raddr = rbin[ADDRESS_BITS-1:0];

   // Next read pointer (binary and Gray), synchronized write pointer in binary,
   // and the occupancy that will hold after this edge.
   always_comb begin
      pop       = rinc & ~rempty;
      rbinnext  = rbin + {{ADDRESS_BITS{1'b0}}, pop};
      rgraynext = (rbinnext >> 1) ^ rbinnext;
      wbin_s    = '0;
      for (int i = 0; i < PtrW; i++) begin
         wbin_s[i] = ^(rq2_write_ptr >> i);
      end
      occ_next  = wbin_s - rbinnext;
   end

   // Pointer, empty flag, count and sticky underflow registers.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin       <= '0;
         rptr       <= '0;
         rempty     <= 1'b1;
         rcount     <= '0;
         runderflow <= 1'b0;
      end else begin
         rbin       <= rbinnext;
         rptr       <= rgraynext;
         // Compare against the next Gray pointer so empty asserts on the
         // same edge that retires the last entry.
         rempty     <= (rgraynext == rq2_write_ptr);
         rcount     <= occ_next;
         runderflow <= runderflow | (rinc & rempty);
      end
   end

`ifdef READ_EMPTY_ALMOST_EN
   localparam logic [PtrW-1:0] AlmostLevel = PtrW'(ALMOST_EMPTY_LEVEL);

   logic almost_q;

   // Almost-empty flag tracks the same next-state occupancy as rcount.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         almost_q <= 1'b1;
      end else begin
         almost_q <= (occ_next <= AlmostLevel);
      end
   end

   assign ralmost_empty = almost_q;
`else
   assign ralmost_empty = 1'b0;
`endif

endmodule
